// File: rtl/fm_mon_packer.sv
// Packs a narrow monitor stream into spy-buffer-width words and owns the lane's
// arm / post-trigger / freeze / release control.
module fm_mon_packer #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned OUT_W      = 256,
    parameter int unsigned POST_WORDS = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_hs,
    input  logic             rst_hs_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_vld,
    input  logic             in_last,
    input  logic             freeze_req,
    input  logic             freeze_clr,
    output logic [OUT_W-1:0] fm_data,
    output logic             fm_vld,
    output logic             freeze,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] dropped_cnt,
    output logic [31:0]      word_cnt
);

    localparam int unsigned RATIO = OUT_W / IN_W;
    localparam int unsigned PTR_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned WC_W  = 32;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_POST   = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic [OUT_W-1:0] pack_q,     pack_d;
    logic [PTR_W-1:0] ptr_q,      ptr_d;
    logic [OUT_W-1:0] fm_data_q,  fm_data_d;
    logic             fm_vld_q,   fm_vld_d;
    logic             freeze_q,   freeze_d;
    logic [CNT_W-1:0] dropped_q,  dropped_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;

    logic             accept;
    logic             emit;
    logic [OUT_W-1:0] merged;

    // Next-state: packing datapath, freeze FSM and counters.
    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        pack_d     = pack_q;
        ptr_d      = ptr_q;
        fm_data_d  = fm_data_q;
        fm_vld_d   = 1'b0;
        dropped_d  = dropped_q;
        word_cnt_d = word_cnt_q;
        freeze_d   = 1'b0;
        merged     = pack_q;

        accept = in_vld && (state_q != ST_FROZEN);
        emit   = accept && ((ptr_q == PTR_W'(RATIO - 1)) || in_last);

        // Pack register is zero above ptr, so merging only the current lane is enough.
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                merged[i*IN_W +: IN_W] = in_data;
            end
        end

        if (accept) begin
            if (emit) begin
                fm_data_d  = merged;
                fm_vld_d   = 1'b1;
                word_cnt_d = word_cnt_q + WC_W'(1);
                pack_d     = '0;
                ptr_d      = '0;
            end else begin
                pack_d = merged;
                ptr_d  = ptr_q + PTR_W'(1);
            end
        end

        case (state_q)
            ST_ARMED: begin
                if (freeze_req) begin
                    if (POST_WORDS == 0) begin
                        state_d = ST_FROZEN;
                    end else begin
                        state_d    = ST_POST;
                        post_cnt_d = CNT_W'(POST_WORDS);
                    end
                end
            end
            ST_POST: begin
                if (emit) begin
                    post_cnt_d = post_cnt_q - CNT_W'(1);
                    if (post_cnt_q == CNT_W'(1)) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            ST_FROZEN: begin
                if (in_vld && (dropped_q != {CNT_W{1'b1}})) begin
                    dropped_d = dropped_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase

        // Release overrides everything, including a simultaneous trigger.
        if (freeze_clr) begin
            state_d    = ST_ARMED;
            post_cnt_d = '0;
            dropped_d  = '0;
        end

        // Any partial word is discarded on entry to FROZEN.
        if ((state_d == ST_FROZEN) && (state_q != ST_FROZEN)) begin
            pack_d = '0;
            ptr_d  = '0;
        end

        freeze_d = (state_d == ST_FROZEN);
    end

    always_ff @(posedge clk_hs) begin
        if (!rst_hs_n) begin
            state_q    <= ST_ARMED;
            post_cnt_q <= '0;
            pack_q     <= '0;
            ptr_q      <= '0;
            fm_data_q  <= '0;
            fm_vld_q   <= 1'b0;
            freeze_q   <= 1'b0;
            dropped_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
            pack_q     <= pack_d;
            ptr_q      <= ptr_d;
            fm_data_q  <= fm_data_d;
            fm_vld_q   <= fm_vld_d;
            freeze_q   <= freeze_d;
            dropped_q  <= dropped_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign fm_data     = fm_data_q;
    assign fm_vld      = fm_vld_q;
    assign freeze      = freeze_q;
    assign state_o     = state_q;
    assign dropped_cnt = dropped_q;
    assign word_cnt    = word_cnt_q;

endmodule
